// File: rtl/cmd_desc_pkg.sv
// -----------------------------------------------------------------------------
// cmd_desc_pkg
// Shared constants and types for the descriptor read responder: AXI response
// codes, burst type encodings, the FSM state type and the descriptor word size.
// -----------------------------------------------------------------------------
package cmd_desc_pkg;

  // AXI RRESP codes. RESP_POIS is the SLVERR encoding, reused to flag a
  // poisoned descriptor word.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_POIS   = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXI ARBURST encodings. Any value other than FIXED is handled as INCR.
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Only 4-byte transfers are supported.
  localparam logic [2:0]  SIZE_WORD  = 3'd2;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage : cmd_desc_pkg

// File: rtl/desc_word_ram.sv
// -----------------------------------------------------------------------------
// desc_word_ram
// DEPTH x 32-bit descriptor word store with one synchronous write port and one
// asynchronous (combinational) read port. When DESC_POISON_EN is defined, a
// 1-bit poison flag is stored alongside each word; otherwise rpoison_o is 0.
//
// Ports
//   clk        clock
//   we_i       write strobe (write happens on the next rising edge)
//   waddr_i    write word index
//   wdata_i    write data
//   wpoison_i  poison flag written with the word (unused without the macro)
//   raddr_i    read word index
//   rdata_o    word at raddr_i
//   rpoison_o  poison flag at raddr_i
//
// Configuration macro: DESC_POISON_EN
// -----------------------------------------------------------------------------
module desc_word_ram #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          wpoison_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  output logic          rpoison_o
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch on purpose -- contents survive reset,
  // and a reset on every word would turn the array into a flop bank.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

`ifdef DESC_POISON_EN
  logic poison_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) poison_q[waddr_i] <= wpoison_i;
  end

  assign rpoison_o = poison_q[raddr_i];
`else
  // Poison storage is compiled out; the write flag is intentionally dropped.
  logic unused_poison;
  assign unused_poison = wpoison_i;
  assign rpoison_o     = 1'b0;
`endif

endmodule : desc_word_ram

// File: rtl/cmd_desc_rd_responder.sv
// -----------------------------------------------------------------------------
// cmd_desc_rd_responder
// AXI read-channel subordinate serving the descriptor/link-header memory that
// the DMA command FSM fetches. One AR request is accepted at a time and
// answered with ARLEN+1 beats of 32-bit words, zero-extended onto RDATA.
// A sideband write port preloads descriptor words.
//
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID, ARREADY   read address channel
//   RID/RDATA/RRESP/RLAST/RVALID, RREADY                read data channel
//   cfg_we/cfg_addr/cfg_wdata/cfg_poison                descriptor preload
//   busy                      high while a burst is in progress
//
// Each beat returns DECERR with zero data when ARSIZE is not 4 bytes, the beat
// address is misaligned, below BASE_ADDR, or past the last word.
//
// Configuration macro: DESC_POISON_EN (poisoned words answer RESP_POIS).
// -----------------------------------------------------------------------------
module cmd_desc_rd_responder
  import cmd_desc_pkg::*;
#(
  parameter  int          DEPTH         = 256,
  parameter  logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter  int          DATA_W        = 128,
  parameter  bit          FIXED_AS_INCR = 1'b1,
  localparam int          AW            = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        ARID,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [3:0]        RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic              cfg_poison,
  output logic              busy
);

  state_e      state_q, state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] addr_q, addr_d;        // byte address of the next beat to load
  logic [3:0]  remaining_q, remaining_d;  // beats still to load after the one on R
  logic        size_err_q, size_err_d;
  logic        fixed_q, fixed_d;

  // The single read port looks at ARADDR while idle (first beat is loaded on
  // the accept edge) and at the stored burst address otherwise.
  logic [31:0] beat_addr;
  logic [31:0] beat_idx;
  logic        beat_size_err;
  logic        beat_decerr;
  logic [31:0] ram_rdata;
  logic        ram_rpoison;
  logic [1:0]  beat_resp;
  logic [31:0] beat_data;

  assign beat_addr     = (state_q == IDLE) ? ARADDR : addr_q;
  assign beat_size_err = (state_q == IDLE) ? (ARSIZE != SIZE_WORD) : size_err_q;
  assign beat_idx      = (beat_addr - BASE_ADDR) >> 2;
  assign beat_decerr   = beat_size_err
                      || (beat_addr[1:0] != 2'b00)
                      || (beat_addr < BASE_ADDR)
                      || (beat_idx >= 32'(DEPTH));

  // Sideband writes are suppressed while reset is asserted.
  desc_word_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .we_i      (cfg_we && resetn),
    .waddr_i   (cfg_addr),
    .wdata_i   (cfg_wdata),
    .wpoison_i (cfg_poison),
    .raddr_i   (beat_idx[AW-1:0]),
    .rdata_o   (ram_rdata),
    .rpoison_o (ram_rpoison)
  );

  always_comb begin
    beat_resp = RESP_OKAY;
    beat_data = ram_rdata;
    if (beat_decerr) begin
      beat_resp = RESP_DECERR;
      beat_data = '0;
    end else if (ram_rpoison) begin
      beat_resp = RESP_POIS;
    end
  end

  // FIXED bursts walk the array like INCR unless FIXED_AS_INCR is cleared.
  function automatic logic [31:0] step_of(input logic fixed);
    return (fixed && !FIXED_AS_INCR) ? 32'd0 : 32'(WORD_BYTES);
  endfunction

  // NOTE: every signal driven here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    size_err_d  = size_err_q;
    fixed_d     = fixed_q;

    unique case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          state_d     = BURST;
          arready_d   = 1'b0;
          rid_d       = ARID;
          size_err_d  = (ARSIZE != SIZE_WORD);
          fixed_d     = (ARBURST == BURST_FIXED);
          rvalid_d    = 1'b1;
          rdata_d     = beat_data;
          rresp_d     = beat_resp;
          rlast_d     = (ARLEN == 4'd0);
          remaining_d = ARLEN;
          addr_d      = ARADDR + step_of(ARBURST == BURST_FIXED);
        end
      end
      BURST: begin
        if (rvalid_q && RREADY) begin
          if (rlast_q) begin
            state_d   = IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            rdata_d     = beat_data;
            rresp_d     = beat_resp;
            rlast_d     = (remaining_q == 4'd1);
            remaining_d = remaining_q - 4'd1;
            addr_d      = addr_q + step_of(fixed_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rid_q       <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      addr_q      <= '0;
      remaining_q <= '0;
      size_err_q  <= 1'b0;
      fixed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      size_err_q  <= size_err_d;
      fixed_q     <= fixed_d;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = {{(DATA_W-32){1'b0}}, rdata_q};
  assign busy    = (state_q == BURST);

endmodule : cmd_desc_rd_responder
